// File: rtl/clk_div_ramp_ctrl.sv
// clk_div_ramp_ctrl: walks the downstream integer clock divider toward a requested
// division factor in bounded steps, holding each intermediate value for a dwell time.
module clk_div_ramp_ctrl #(
   parameter int unsigned DIV_VALUE_WIDTH   = 4,
   parameter int unsigned DEFAULT_DIV_VALUE = 1,
   parameter int unsigned DWELL_WIDTH       = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [DIV_VALUE_WIDTH-1:0] target_div_i,
   input  logic                       target_valid_i,
   output logic                       target_ready_o,
   input  logic [DIV_VALUE_WIDTH-1:0] step_i,
   input  logic [DWELL_WIDTH-1:0]     dwell_i,
   input  logic                       abort_i,
   output logic [DIV_VALUE_WIDTH-1:0] div_o,
   output logic                       div_valid_o,
   input  logic                       div_ready_i,
   output logic [DIV_VALUE_WIDTH-1:0] cur_div_o,
   output logic                       busy_o,
   output logic                       done_o
);

   localparam int unsigned W  = DIV_VALUE_WIDTH;
   localparam int unsigned DW = DWELL_WIDTH;

   // The reset value must be representable by the divider.
   if (DEFAULT_DIV_VALUE >= (1 << W)) begin : g_bad_default
      $error("DEFAULT_DIV_VALUE does not fit in DIV_VALUE_WIDTH");
   end

   localparam logic [W-1:0] DEF_DIV = (DEFAULT_DIV_VALUE == 0) ? W'(1) : W'(DEFAULT_DIV_VALUE);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DWELL = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [W-1:0]   cur_q, cur_d;
   logic [W-1:0]   div_q, div_d;
   logic [W-1:0]   tgt_q, tgt_d;
   logic [W-1:0]   stp_q, stp_d;
   logic [DW-1:0]  dwl_q, dwl_d;
   logic [DW-1:0]  cnt_q, cnt_d;
   logic           valid_q, valid_d;
   logic           ready_q, ready_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic [W-1:0]   tgt_in_c;
   logic [W-1:0]   stp_in_c;

   // One bounded step from cur toward tgt, evaluated one bit wider so it cannot wrap.
   function automatic logic [W-1:0] step_toward(input logic [W-1:0] cur,
                                                input logic [W-1:0] tgt,
                                                input logic [W-1:0] stp);
      logic [W:0] c, t, s, d, r;
      c = {1'b0, cur};
      t = {1'b0, tgt};
      s = {1'b0, stp};
      r = c;
      if (t > c) begin
         d = t - c;
         r = c + ((s < d) ? s : d);
      end else if (t < c) begin
         d = c - t;
         r = c - ((s < d) ? s : d);
      end
      return W'(r);
   endfunction

   // Zero requests are treated as one.
   assign tgt_in_c = (target_div_i == '0) ? W'(1) : target_div_i;
   assign stp_in_c = (step_i == '0) ? W'(1) : step_i;

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cur_q   <= DEF_DIV;
         div_q   <= DEF_DIV;
         tgt_q   <= DEF_DIV;
         stp_q   <= W'(1);
         dwl_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         div_q   <= div_d;
         tgt_q   <= tgt_d;
         stp_q   <= stp_d;
         dwl_q   <= dwl_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic; handshake flags are derived from the next state so they are flopped.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      div_d   = div_q;
      tgt_d   = tgt_q;
      stp_d   = stp_q;
      dwl_d   = dwl_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (target_valid_i && ready_q) begin
               tgt_d = tgt_in_c;
               stp_d = stp_in_c;
               dwl_d = dwell_i;
               if (tgt_in_c == cur_q) begin
                  done_d = 1'b1;
               end else begin
                  div_d   = step_toward(cur_q, tgt_in_c, stp_in_c);
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            // Valid is never withdrawn, so abort is not looked at here.
            if (valid_q && div_ready_i) begin
               cur_d = div_q;
               if (div_q == tgt_q) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  cnt_d   = dwl_q;
                  state_d = DWELL;
               end
            end
         end
         DWELL: begin
            if (abort_i) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               div_d   = step_toward(cur_q, tgt_q, stp_q);
               state_d = ISSUE;
            end else begin
               cnt_d = cnt_q - DW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ready_d = (state_d == IDLE);
      valid_d = (state_d == ISSUE);
      busy_d  = (state_d != IDLE);
   end

   assign target_ready_o = ready_q;
   assign div_o          = div_q;
   assign div_valid_o    = valid_q;
   assign cur_div_o      = cur_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;

endmodule

// File: tb/tb_clk_div_ramp_ctrl.sv
// Directed bench for clk_div_ramp_ctrl with an immediately-granting divider model.
module tb_clk_div_ramp_ctrl;

   logic       clk;
   logic       rst_n;
   logic [3:0] target_div_i;
   logic       target_valid_i;
   logic       target_ready_o;
   logic [3:0] step_i;
   logic [7:0] dwell_i;
   logic       abort_i;
   logic [3:0] div_o;
   logic       div_valid_o;
   logic       div_ready_i;
   logic [3:0] cur_div_o;
   logic       busy_o;
   logic       done_o;

   int checks   = 0;
   int failures = 0;

   int hs[$];
   int done_cnt;
   int min_gap;

   clk_div_ramp_ctrl #(
      .DIV_VALUE_WIDTH  (4),
      .DEFAULT_DIV_VALUE(1),
      .DWELL_WIDTH      (8)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .target_div_i  (target_div_i),
      .target_valid_i(target_valid_i),
      .target_ready_o(target_ready_o),
      .step_i        (step_i),
      .dwell_i       (dwell_i),
      .abort_i       (abort_i),
      .div_o         (div_o),
      .div_valid_o   (div_valid_o),
      .div_ready_i   (div_ready_i),
      .cur_div_o     (cur_div_o),
      .busy_o        (busy_o),
      .done_o        (done_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present a request at this negedge; on return the request has been taken and the
   // inputs are scrambled so any late sampling would show up.
   task automatic request(input logic [3:0] tgt, input logic [3:0] stp, input logic [7:0] dwl);
      target_div_i   = tgt;
      step_i         = stp;
      dwell_i        = dwl;
      target_valid_i = 1'b1;
      chk("ready_before_accept", 32'(target_ready_o), 32'd1);
      @(negedge clk);
      target_valid_i = 1'b0;
      target_div_i   = 4'd2;
      step_i         = 4'd15;
      dwell_i        = 8'd0;
   endtask

   // Divider that grants every valid at once; logs handshakes, done pulses and valid spacing.
   task automatic run_divider(input int cyc, input bit abort_after_first);
      int last_ack;
      last_ack = -1;
      hs.delete();
      done_cnt = 0;
      min_gap  = 999;
      for (int i = 0; i < cyc; i++) begin
         if (abort_after_first && hs.size() > 0) abort_i = 1'b1;
         if (div_valid_o) begin
            if (last_ack >= 0 && (i - last_ack) < min_gap) min_gap = i - last_ack;
            hs.push_back(int'(div_o));
            last_ack = i;
         end
         div_ready_i = div_valid_o;
         if (done_o) begin
            done_cnt++;
            chk("busy_low_at_done", 32'(busy_o), 32'd0);
         end
         @(negedge clk);
      end
      div_ready_i = 1'b0;
      abort_i     = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      target_div_i   = '0;
      target_valid_i = 1'b0;
      step_i         = '0;
      dwell_i        = '0;
      abort_i        = 1'b0;
      div_ready_i    = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      chk("rst_valid", 32'(div_valid_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_cur", 32'(cur_div_o), 32'd1);
      chk("rst_div", 32'(div_o), 32'd1);
      chk("rst_ready", 32'(target_ready_o), 32'd1);

      // Spurious ready while idle changes nothing
      div_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      div_ready_i = 1'b0;
      chk("spurious_cur", 32'(cur_div_o), 32'd1);
      chk("spurious_valid", 32'(div_valid_o), 32'd0);

      // Already current: done one cycle after acceptance, no handshake
      request(4'd1, 4'd3, 8'd4);
      chk("cur_done", 32'(done_o), 32'd1);
      chk("cur_ready", 32'(target_ready_o), 32'd1);
      chk("cur_busy", 32'(busy_o), 32'd0);
      chk("cur_valid", 32'(div_valid_o), 32'd0);
      @(negedge clk);
      chk("cur_done_width", 32'(done_o), 32'd0);
      run_divider(10, 1'b0);
      chk("cur_no_hs", 32'(hs.size()), 32'd0);

      // Up ramp 1 -> 9, step 3, dwell 4: 4, 7, 9; ack-to-next-valid = dwell + 2
      request(4'd9, 4'd3, 8'd4);
      run_divider(60, 1'b0);
      chk("up_hs_count", 32'(hs.size()), 32'd3);
      if (hs.size() == 3) begin
         chk("up_hs0", 32'(hs[0]), 32'd4);
         chk("up_hs1", 32'(hs[1]), 32'd7);
         chk("up_hs2", 32'(hs[2]), 32'd9);
      end
      chk("up_gap", 32'(min_gap), 32'd6);
      chk("up_done_cnt", 32'(done_cnt), 32'd1);
      chk("up_cur", 32'(cur_div_o), 32'd9);
      chk("up_busy", 32'(busy_o), 32'd0);

      // Down ramp 9 -> 0(=1), step 0(=1), dwell 0: 8..1, valids two cycles apart
      request(4'd0, 4'd0, 8'd0);
      run_divider(60, 1'b0);
      chk("down_hs_count", 32'(hs.size()), 32'd8);
      if (hs.size() == 8) begin
         chk("down_first", 32'(hs[0]), 32'd8);
         chk("down_last", 32'(hs[7]), 32'd1);
      end
      chk("down_gap", 32'(min_gap), 32'd2);
      chk("down_done_cnt", 32'(done_cnt), 32'd1);
      chk("down_cur", 32'(cur_div_o), 32'd1);

      // Backpressure 1 -> 9 step 2: first value 3 held for 20 cycles, abort ignored in ISSUE
      request(4'd9, 4'd2, 8'd3);
      for (int i = 0; i < 20; i++) begin
         abort_i = ~abort_i;
         chk("bp_valid", 32'(div_valid_o), 32'd1);
         chk("bp_div", 32'(div_o), 32'd3);
         @(negedge clk);
      end
      abort_i     = 1'b0;
      div_ready_i = 1'b1;
      @(negedge clk);
      div_ready_i = 1'b0;
      chk("bp_cur_after_ack", 32'(cur_div_o), 32'd3);
      chk("bp_in_dwell_busy", 32'(busy_o), 32'd1);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      chk("bp_abort_done", 32'(done_o), 32'd1);
      chk("bp_abort_cur", 32'(cur_div_o), 32'd3);
      chk("bp_abort_valid", 32'(div_valid_o), 32'd0);

      // Async reset mid-ISSUE: outputs return without a clock edge
      request(4'd9, 4'd1, 8'd2);
      chk("ar_valid_before", 32'(div_valid_o), 32'd1);
      rst_n = 1'b0;
      #2;
      chk("ar_valid", 32'(div_valid_o), 32'd0);
      chk("ar_busy", 32'(busy_o), 32'd0);
      chk("ar_cur", 32'(cur_div_o), 32'd1);
      chk("ar_div", 32'(div_o), 32'd1);
      #2;
      rst_n = 1'b1;
      @(negedge clk);

      // Abort in DWELL: 1 -> 15 step 2 dwell 10, abort after first ack
      request(4'd15, 4'd2, 8'd10);
      run_divider(40, 1'b1);
      chk("ab_hs_count", 32'(hs.size()), 32'd1);
      if (hs.size() == 1) chk("ab_hs0", 32'(hs[0]), 32'd3);
      chk("ab_done_cnt", 32'(done_cnt), 32'd1);
      chk("ab_cur", 32'(cur_div_o), 32'd3);
      chk("ab_busy", 32'(busy_o), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
